// File: rtl/alu_sequencer_if.sv
// Bus between the switch/strobe inputs and the ALU sequencer outputs.
// master: drives data_in, op_in and load, and observes the captured values,
//         the result, the flags and the status.
// slave : the sequencer side of the same signals.
interface alu_sequencer_if #(
    parameter int unsigned NBITS  = 4,
    parameter int unsigned NCOUNT = 8
);
    logic [NBITS-1:0]  data_in;
    logic [1:0]        op_in;
    logic              load;
    logic [NBITS-1:0]  operand_a;
    logic [NBITS-1:0]  operand_b;
    logic [1:0]        op_q;
    logic [NBITS-1:0]  result;
    logic              carry;
    logic              overflow;
    logic              zero;
    logic              done;
    logic [2:0]        state;
    logic [NCOUNT-1:0] op_count;

    modport master (
        output data_in, op_in, load,
        input  operand_a, operand_b, op_q, result, carry, overflow, zero,
               done, state, op_count
    );

    modport slave (
        input  data_in, op_in, load,
        output operand_a, operand_b, op_q, result, carry, overflow, zero,
               done, state, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: captures A, B and the ALU select from a shared input on
// successive load strobes, executes once, then holds the result for display.
// Ports:
//   clk_2 - system clock
//   reset - asynchronous, active-high reset
//   bus   - alu_sequencer_if.slave: data_in/op_in/load in; captured operands,
//           result, carry/overflow/zero flags, done, state, op_count out
module alu_sequencer #(
    parameter int unsigned NBITS  = 4,
    parameter int unsigned NCOUNT = 8
) (
    input  logic           clk_2,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_F    = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_SUB = 2'b01;
    localparam logic [1:0] F_AND = 2'b10;

    state_t            state_q, state_d;
    logic              load_q;
    logic [NBITS-1:0]  a_q, a_d;
    logic [NBITS-1:0]  b_q, b_d;
    logic [1:0]        f_q, f_d;
    logic [NBITS-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic [NCOUNT-1:0] cnt_q, cnt_d;

    logic              load_edge;
    logic [NBITS:0]    sum;
    logic [NBITS:0]    diff;
    logic [NBITS-1:0]  exec_res;
    logic              exec_carry;
    logic              exec_ovf;

    // load_q resets high so a strobe held through reset is not an edge
    assign load_edge = bus.load & ~load_q;

    // Extra MSB of the unsigned sum is the carry; of the difference, the borrow
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // ALU datapath on the captured operands
    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_ovf   = 1'b0;
        case (f_q)
            F_ADD: begin
                exec_res   = sum[NBITS-1:0];
                exec_carry = sum[NBITS];
                exec_ovf   = (a_q[NBITS-1] == b_q[NBITS-1]) &
                             (sum[NBITS-1] != a_q[NBITS-1]);
            end
            F_SUB: begin
                exec_res   = diff[NBITS-1:0];
                exec_carry = diff[NBITS];
                exec_ovf   = (a_q[NBITS-1] != b_q[NBITS-1]) &
                             (diff[NBITS-1] != a_q[NBITS-1]);
            end
            F_AND:   exec_res = a_q & b_q;
            default: exec_res = a_q | b_q;
        endcase
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_A: begin
                if (load_edge) begin
                    a_d     = bus.data_in;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (load_edge) begin
                    b_d     = bus.data_in;
                    state_d = S_F;
                end
            end
            S_F: begin
                if (load_edge) begin
                    f_d     = bus.op_in;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = exec_res;
                carry_d = exec_carry;
                ovf_d   = exec_ovf;
                zero_d  = (exec_res == '0);
                cnt_d   = cnt_q + NCOUNT'(1);
                state_d = S_SHOW;
            end
            S_SHOW: begin
                // The edge that leaves S_SHOW is also the A capture of the next operation
                if (load_edge) begin
                    a_d     = bus.data_in;
                    state_d = S_B;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= S_A;
            load_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= bus.load;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.operand_a = a_q;
    assign bus.operand_b = b_q;
    assign bus.op_q      = f_q;
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.done      = (state_q == S_SHOW);
    assign bus.state     = state_q;
    assign bus.op_count  = cnt_q;
endmodule
